// File: rtl/lsu_axi_delay_bridge_if.sv
// AXI-lite channel bundle (AR, AW, W, R, B) shared by the LSU-side and SRAM-side ports.
// The master modport drives requests; the slave modport drives readies and responses.
interface lsu_axi_delay_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, input arready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  rdata, rresp, rvalid, output rready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output rdata, rresp, rvalid, input rready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/lsu_axi_delay_bridge.sv
// LSU <-> data SRAM AXI-lite bridge; every channel is registered and held for a
// zero, fixed or LFSR-random delay. Read data is lane-selected and extended per load type.
module lsu_axi_delay_chan #(
    parameter int W     = 1,
    parameter int DLY_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [DLY_W-1:0] dly,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data
);
    typedef enum logic [1:0] {IDLE, DELAY, SEND} state_t;

    state_t           state, state_nxt;
    logic [DLY_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            if (in_valid && in_ready) begin
                out_data <= in_data;
                cnt      <= dly;
            end else if (state == DELAY) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = en;
                if (in_valid && en) state_nxt = (dly == '0) ? SEND : DELAY;
            end
            DELAY: if (cnt <= DLY_W'(1)) state_nxt = SEND;
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

module lsu_axi_delay_bridge #(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          DLY_W     = 4,
    parameter int          FIX_DLY   = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  dly_mode,
    input  logic [2:0]                  mrtype,
    lsu_axi_delay_bridge_if.slave       m,
    lsu_axi_delay_bridge_if.master      s
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);

    logic [15:0]               lfsr;
    logic [4:0][DLY_W-1:0]     dly;
    logic                      rd_busy, aw_done, w_done;
    logic [2:0]                rtype_q;
    logic [LANE_W-1:0]         lane_q, lane_w;
    logic [7:0]                sel_b;
    logic [15:0]               sel_h;
    logic [31:0]               sel_w;
    logic [DATA_W-1:0]         r_ext;
    logic [DATA_W+STRB_W-1:0]  w_out;
    logic [DATA_W+1:0]         r_out;
    logic                      ar_hs, aw_hs, w_hs, r_hs, b_hs;

    assign ar_hs = m.arvalid & m.arready;
    assign aw_hs = m.awvalid & m.awready;
    assign w_hs  = m.wvalid  & m.wready;
    assign r_hs  = m.rvalid  & m.rready;
    assign b_hs  = m.bvalid  & m.bready;

    // Galois form of x^16+x^14+x^13+x^11+1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Channel k draws its random delay from lfsr bits starting at 3k
    always_comb begin
        dly = '0;
        for (int k = 0; k < 5; k++) begin
            case (dly_mode)
                2'd0:    dly[k] = '0;
                2'd1:    dly[k] = DLY_W'(FIX_DLY);
                default: dly[k] = DLY_W'(lfsr >> (3 * k));
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_busy <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rtype_q <= '0;
            lane_q  <= '0;
        end else begin
            if (ar_hs) begin
                rd_busy <= 1'b1;
                rtype_q <= mrtype;
                lane_q  <= m.araddr[LANE_W-1:0];
            end else if (r_hs) begin
                rd_busy <= 1'b0;
            end
            if (aw_hs)     aw_done <= 1'b1;
            else if (b_hs) aw_done <= 1'b0;
            if (w_hs)      w_done  <= 1'b1;
            else if (b_hs) w_done  <= 1'b0;
        end
    end

    always_comb begin
        lane_w = lane_q & ~LANE_W'(3);
        sel_b  = 8'(s.rdata >> {lane_q, 3'b000});
        sel_h  = 16'(s.rdata >> {lane_q[LANE_W-1:1], 4'b0000});
        sel_w  = 32'(s.rdata >> {lane_w, 3'b000});
        case (rtype_q)
            3'd0:    r_ext = DATA_W'($signed(sel_b));
            3'd1:    r_ext = DATA_W'($signed(sel_h));
            3'd2:    r_ext = DATA_W'($signed(sel_w));
            3'd3:    r_ext = DATA_W'(sel_b);
            3'd4:    r_ext = DATA_W'(sel_h);
            default: r_ext = '0;
        endcase
    end

    lsu_axi_delay_chan #(.W(ADDR_W), .DLY_W(DLY_W)) u_ar (
        .clk(clk), .rst_n(rst_n), .en(!rd_busy),
        .in_valid(m.arvalid), .in_ready(m.arready), .in_data(m.araddr), .dly(dly[0]),
        .out_valid(s.arvalid), .out_ready(s.arready), .out_data(s.araddr)
    );

    lsu_axi_delay_chan #(.W(ADDR_W), .DLY_W(DLY_W)) u_aw (
        .clk(clk), .rst_n(rst_n), .en(!aw_done),
        .in_valid(m.awvalid), .in_ready(m.awready), .in_data(m.awaddr), .dly(dly[1]),
        .out_valid(s.awvalid), .out_ready(s.awready), .out_data(s.awaddr)
    );

    lsu_axi_delay_chan #(.W(DATA_W + STRB_W), .DLY_W(DLY_W)) u_w (
        .clk(clk), .rst_n(rst_n), .en(!w_done),
        .in_valid(m.wvalid), .in_ready(m.wready), .in_data({m.wdata, m.wstrb}), .dly(dly[2]),
        .out_valid(s.wvalid), .out_ready(s.wready), .out_data(w_out)
    );
    assign {s.wdata, s.wstrb} = w_out;

    lsu_axi_delay_chan #(.W(DATA_W + 2), .DLY_W(DLY_W)) u_r (
        .clk(clk), .rst_n(rst_n), .en(1'b1),
        .in_valid(s.rvalid), .in_ready(s.rready), .in_data({s.rresp, r_ext}), .dly(dly[3]),
        .out_valid(m.rvalid), .out_ready(m.rready), .out_data(r_out)
    );
    assign {m.rresp, m.rdata} = r_out;

    lsu_axi_delay_chan #(.W(2), .DLY_W(DLY_W)) u_b (
        .clk(clk), .rst_n(rst_n), .en(1'b1),
        .in_valid(s.bvalid), .in_ready(s.bready), .in_data(s.bresp), .dly(dly[4]),
        .out_valid(m.bvalid), .out_ready(m.bready), .out_data(m.bresp)
    );
endmodule

// File: tb/tb_lsu_axi_delay_bridge.sv
// Directed and randomised bench for lsu_axi_delay_bridge with a simple SRAM slave model.
`timescale 1ns/1ps
module tb_lsu_axi_delay_bridge;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dly_mode;
    logic [2:0] mrtype;
    int         cyc = 0;
    int         cnt_cmp = 0;
    int         cnt_bad = 0;

    lsu_axi_delay_bridge_if #(.ADDR_W(32), .DATA_W(32)) m();
    lsu_axi_delay_bridge_if #(.ADDR_W(32), .DATA_W(32)) s();

    lsu_axi_delay_bridge #(
        .ADDR_W(32), .DATA_W(32), .DLY_W(4), .FIX_DLY(3), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dly_mode(dly_mode), .mrtype(mrtype), .m(m), .s(s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        cnt_cmp++;
        if (got !== exp) begin
            cnt_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ext_model(input logic [31:0] v, input logic [1:0] ln,
                                              input logic [2:0] rt);
        logic [7:0]  b;
        logic [15:0] h;
        b = v[8*ln +: 8];
        h = ln[1] ? v[31:16] : v[15:0];
        case (rt)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return v;
            3'd3:    return {24'h0, b};
            3'd4:    return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    // SRAM slave model
    logic [31:0] slv_rdata;
    logic [1:0]  slv_rresp, slv_bresp;
    bit          slv_rnd;
    logic [31:0] sr_addr, sw_addr, sw_data;
    logic [3:0]  sw_strb;
    logic        got_aw, got_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.arready <= 1'b1; s.awready <= 1'b1; s.wready <= 1'b1;
            s.rvalid <= 1'b0; s.rdata <= '0; s.rresp <= '0;
            s.bvalid <= 1'b0; s.bresp <= '0;
            got_aw <= 1'b0; got_w <= 1'b0;
        end else begin
            s.arready <= slv_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s.awready <= slv_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s.wready  <= slv_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s.arvalid && s.arready) begin
                s.rvalid <= 1'b1; s.rdata <= slv_rdata; s.rresp <= slv_rresp; sr_addr <= s.araddr;
            end else if (s.rvalid && s.rready) begin
                s.rvalid <= 1'b0;
            end
            if (s.awvalid && s.awready) begin got_aw <= 1'b1; sw_addr <= s.awaddr; end
            if (s.wvalid && s.wready) begin got_w <= 1'b1; sw_data <= s.wdata; sw_strb <= s.wstrb; end
            if (got_aw && got_w && !s.bvalid) begin
                s.bvalid <= 1'b1; s.bresp <= slv_bresp; got_aw <= 1'b0; got_w <= 1'b0;
            end else if (s.bvalid && s.bready) begin
                s.bvalid <= 1'b0;
            end
        end
    end

    // Mid-cycle monitor: hold/stability under backpressure and rise timestamps
    logic        p_rv = 0, p_rr = 0, p_av = 0, p_ar = 0;
    logic [33:0] p_rd = '0;
    logic [31:0] p_aa = '0;
    logic        q_ar = 0, q_aw = 0, q_w = 0, q_mr = 0;
    int          t_ar = 0, t_aw = 0, t_w = 0, t_mrv = 0, t_srh = 0;

    always begin
        @(negedge clk);
        #2;
        if (rst_n && p_rv && !p_rr) begin
            chk("r_hold", m.rvalid, 1);
            chk("r_stable", {m.rresp, m.rdata}, p_rd);
        end
        if (rst_n && p_av && !p_ar) begin
            chk("ar_hold", s.arvalid, 1);
            chk("ar_stable", s.araddr, p_aa);
        end
        if (s.arvalid && !q_ar) t_ar = cyc;
        if (s.awvalid && !q_aw) t_aw = cyc;
        if (s.wvalid && !q_w)   t_w = cyc;
        if (m.rvalid && !q_mr)  t_mrv = cyc;
        if (s.rvalid && s.rready) t_srh = cyc;
        q_ar = s.arvalid; q_aw = s.awvalid; q_w = s.wvalid; q_mr = m.rvalid;
        p_rv = rst_n && m.rvalid; p_rr = m.rready; p_rd = {m.rresp, m.rdata};
        p_av = rst_n && s.arvalid; p_ar = s.arready; p_aa = s.araddr;
    end

    task automatic do_rd(input logic [31:0] a, input logic [2:0] rt, input bit rnd,
                         output logic [31:0] d, output logic [1:0] rs, output int dl);
        int n, t0;
        d = '0; rs = '0;
        m.araddr = a; mrtype = rt; m.arvalid = 1'b1; n = 0;
        while (!m.arready && n < 200) begin @(negedge clk); n++; end
        if (!m.arready) chk("ar_timeout", 0, 1);
        t0 = cyc;
        @(negedge clk);
        m.arvalid = 1'b0; mrtype = 3'd7;
        n = 0;
        forever begin
            m.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m.rvalid && m.rready) begin d = m.rdata; rs = m.rresp; break; end
            if (n >= 200) begin chk("r_timeout", 0, 1); break; end
            @(negedge clk); n++;
        end
        @(negedge clk);
        m.rready = 1'b1;
        dl = t_ar - t0 - 1;
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                         input bit rnd, output logic [1:0] br);
        int n;
        br = '0;
        m.awaddr = a; m.awvalid = 1'b1; m.wdata = wd; m.wstrb = st; m.wvalid = 1'b1; n = 0;
        while (!(m.awready && m.wready) && n < 200) begin @(negedge clk); n++; end
        if (!(m.awready && m.wready)) chk("aw_w_timeout", 0, 1);
        @(negedge clk);
        m.awvalid = 1'b0; m.wvalid = 1'b0;
        n = 0;
        forever begin
            m.bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m.bvalid && m.bready) begin br = m.bresp; break; end
            if (n >= 200) begin chk("b_timeout", 0, 1); break; end
            @(negedge clk); n++;
        end
        @(negedge clk);
        m.bready = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, a, wd, exp_d;
        logic [1:0]  rs, br;
        logic [2:0]  rt;
        logic [3:0]  st;
        int          dl, n, tw, taw;
        bit          seen;

        m.arvalid = 0; m.araddr = '0; m.awvalid = 0; m.awaddr = '0;
        m.wvalid = 0; m.wdata = '0; m.wstrb = '0; m.rready = 1; m.bready = 1;
        dly_mode = 2'd0; mrtype = 3'd0;
        slv_rdata = '0; slv_rresp = '0; slv_bresp = '0; slv_rnd = 0;

        repeat (2) @(negedge clk);
        chk("rst_valids", {s.arvalid, s.awvalid, s.wvalid, m.rvalid, m.bvalid}, 0);
        chk("rst_lfsr", dut.lfsr, 16'hACE1);
        chk("rst_payload", {s.araddr, s.awaddr}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", {m.arready, m.awready, m.wready, s.rready, s.bready}, 5'h1f);

        // 1: zero-delay word load
        slv_rdata = 32'hDEADBEEF;
        do_rd(32'h80000004, 3'd2, 0, d, rs, dl);
        chk("t1_ar_dly", dl, 0);
        chk("t1_saraddr", sr_addr, 32'h80000004);
        chk("t1_rdata", d, 32'hDEADBEEF);
        chk("t1_rresp", rs, 0);
        chk("t1_r_lat", t_mrv - t_srh, 1);

        // 2: fixed delay, W three cycles ahead of AW
        dly_mode = 2'd1; slv_bresp = 2'd0;
        m.wdata = 32'h12345678; m.wstrb = 4'hF; m.wvalid = 1'b1;
        chk("t2_wready", m.wready, 1);
        tw = cyc;
        @(negedge clk); m.wvalid = 1'b0;
        repeat (2) @(negedge clk);
        m.awaddr = 32'h80000100; m.awvalid = 1'b1;
        chk("t2_awready", m.awready, 1);
        chk("t2_wready_lo", m.wready, 0);
        taw = cyc;
        @(negedge clk); m.awvalid = 1'b0;
        seen = 0; n = 0;
        while (!m.bvalid && n < 200) begin seen |= m.awready | m.wready; @(negedge clk); n++; end
        chk("t2_rdy_held", seen, 0);
        chk("t2_bvalid", m.bvalid, 1);
        chk("t2_bresp", m.bresp, 0);
        chk("t2_w_dly", t_w - tw, 4);
        chk("t2_aw_dly", t_aw - taw, 4);
        @(negedge clk);
        chk("t2_b_once", m.bvalid, 0);
        chk("t2_rdy_back", {m.awready, m.wready}, 2'b11);
        chk("t2_slv_w", {sw_addr, sw_data, sw_strb}, {32'h80000100, 32'h12345678, 4'hF});

        // 3: lane select and extension
        dly_mode = 2'd0; slv_rdata = 32'h80FFFF7F;
        do_rd(32'h00000003, 3'd0, 0, d, rs, dl); chk("t3_lb", d, 32'hFFFFFF80);
        do_rd(32'h00000003, 3'd3, 0, d, rs, dl); chk("t3_lbu", d, 32'h00000080);
        do_rd(32'h00000002, 3'd4, 0, d, rs, dl); chk("t3_lhu", d, 32'h000080FF);
        do_rd(32'h00000002, 3'd1, 0, d, rs, dl); chk("t3_lh", d, 32'hFFFF80FF);
        do_rd(32'h00000000, 3'd6, 0, d, rs, dl); chk("t3_bad_type", d, 32'h0);

        // 6: error responses pass through
        slv_rdata = 32'h12348765; slv_rresp = 2'b10;
        do_rd(32'h00000010, 3'd1, 0, d, rs, dl);
        chk("t6_rresp", rs, 2'b10);
        chk("t6_rdata", d, 32'hFFFF8765);
        slv_rresp = 2'b00; slv_bresp = 2'b11;
        do_wr(32'h00000020, 32'hA5A5A5A5, 4'h3, 0, br);
        chk("t6_bresp", br, 2'b11);

        // 5: reset with AR in DELAY and B in SEND
        dly_mode = 2'd0; slv_bresp = 2'b00; m.bready = 1'b0;
        m.awaddr = 32'h40; m.awvalid = 1'b1; m.wdata = 32'h1; m.wstrb = 4'h1; m.wvalid = 1'b1;
        @(negedge clk); m.awvalid = 1'b0; m.wvalid = 1'b0;
        n = 0;
        while (!m.bvalid && n < 50) begin @(negedge clk); n++; end
        dly_mode = 2'd1;
        m.araddr = 32'h80; mrtype = 3'd2; m.arvalid = 1'b1;
        @(negedge clk); m.arvalid = 1'b0;
        @(negedge clk);
        chk("t5_pre_b", {m.bvalid, s.arvalid, m.arready}, 3'b100);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valids_drop", {m.bvalid, s.arvalid, m.rvalid, s.awvalid, s.wvalid}, 0);
        chk("t5_lfsr", dut.lfsr, 16'hACE1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; m.bready = 1'b1;
        @(negedge clk);
        chk("t5_rdy", {m.arready, m.awready, m.wready, s.rready, s.bready}, 5'h1f);
        dly_mode = 2'd0; slv_rdata = 32'hCAFEF00D;
        do_rd(32'h80000010, 3'd2, 0, d, rs, dl);
        chk("t5_rdata", d, 32'hCAFEF00D);

        // 4: random delays and backpressure on both sides
        slv_rnd = 1;
        for (int i = 0; i < 1000; i++) begin
            dly_mode = 2'($urandom_range(2, 3));
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom; rt = 3'($urandom_range(0, 7));
                slv_rdata = $urandom; slv_rresp = 2'($urandom);
                exp_d = ext_model(slv_rdata, a[1:0], rt);
                do_rd(a, rt, 1, d, rs, dl);
                chk("t4_rdata", d, exp_d);
                chk("t4_rresp", rs, slv_rresp);
                chk("t4_ar_dly", (dl >= 0) && (dl <= 15), 1);
            end else begin
                a = $urandom; wd = $urandom; st = 4'($urandom); slv_bresp = 2'($urandom);
                do_wr(a, wd, st, 1, br);
                chk("t4_bresp", br, slv_bresp);
                chk("t4_slv_w", {sw_addr, sw_data, sw_strb}, {a, wd, st});
            end
        end
        slv_rnd = 0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
        $finish;
    end
endmodule
